ign_sched: RTL
==============

IGN_SCHED -- requirements
Module: ign_sched

Interface
REQ-001 clk  input  1  system clock; all logic on posedge clk.
REQ-002 rst  input  1  synchronous reset, active-high.
REQ-003 tooth  input  1  one-cycle pulse per decoded crank tooth.
REQ-004 eng_phase  input  16  engine phase in quanta at current tooth.
REQ-005 next_tooth_width  input  16  quanta between current and next tooth.
REQ-006 tooth_period  input  32  clk cycles per tooth, measured.
REQ-007 spark_angle  input  64  packed 4x16 spark angles in quanta; cylinder i at bits [16i+15:16i].
REQ-008 cyl_en  input  4  per-cylinder scheduling enable.
REQ-009 spark  output  4  one-cycle spark pulse, bit i = cylinder i.
REQ-010 chan_busy  output  2  timer channel j holds a pending event.
REQ-011 sched_busy  output  1  FSM not in IDLE.
REQ-012 drop_cnt  output  8  count of events lost for lack of a free channel, saturating at 255.
REQ-013 overrun  output  1  sticky flag: tooth arrived while sched_busy.

Function
REQ-014 The FSM SHALL have states IDLE and SCAN; SCAN lasts exactly 4 cycles, scan index 0..3.
REQ-015 In IDLE, tooth=1 SHALL latch eng_phase, next_tooth_width, tooth_period, spark_angle and cyl_en at that edge, and enter SCAN with index 0.
REQ-016 Each SCAN cycle SHALL evaluate one cylinder i (= index); after index 3 the FSM SHALL return to IDLE (tooth at cycle T -> SCAN T+1..T+4 -> IDLE T+5).
REQ-017 diff_i SHALL be (angle_i - phase) mod 2^16; cylinder i qualifies iff en_i=1, 0 < diff_i <= width (width zero-extended), and i owns no active channel.
REQ-018 Phase wrap-around SHALL be handled solely by the modulo subtraction of REQ-017 (angle 0x0002, phase 0xFFF0 -> diff 0x0012).
REQ-019 Delay d SHALL be (period * diff_i) computed to 48 bits, shifted right by 7; d saturates to 0xFFFFFFFF if bits [47:39] are nonzero.
REQ-020 A qualifying cylinder SHALL be loaded into the lowest-index free channel at the end of its scan cycle, storing d and owner i.
REQ-021 A channel whose spark pulse is being registered at an edge SHALL NOT count as free at that edge; it is free from the following cycle.
REQ-022 A qualifying cylinder with no free channel SHALL increment drop_cnt (saturating) and SHALL NOT be scheduled.
REQ-023 A loaded channel SHALL decrement once per cycle; spark[owner] SHALL be high for exactly one cycle, d+1 edges after the load edge, after which the channel is freed.
REQ-024 Both channels expiring in the same cycle SHALL assert both spark bits in that cycle.
REQ-025 A tooth pulse while sched_busy=1 SHALL be ignored for scheduling and SHALL set overrun; active channels are unaffected.
REQ-026 Changes to the inputs during SCAN SHALL have no effect; only latched values are used.
REQ-027 chan_busy[j] SHALL be high from the cycle after load through the spark cycle, inclusive.

Reset
REQ-028 rst=1 SHALL force FSM to IDLE, spark=0, chan_busy=0, sched_busy=0, drop_cnt=0 and overrun=0, and free both channels.
REQ-029 Reset mid-SCAN or with channels pending SHALL cancel every pending spark; no spark pulse SHALL occur after the reset edge until a new schedule.
REQ-030 All outputs SHALL be registered.

Verification
REQ-031 Basic timing: period=1280, phase=100, width=32, angle0=116, en=0001, tooth at T -> ch0 loaded at T+1; spark=0001 one cycle only at T+1+161.
REQ-032 Channel exhaustion: en=0111, all angles in window, long delays -> cyl0->ch0, cyl1->ch1, cyl2 dropped, drop_cnt=1; chan_busy=11.
REQ-033 Wrap and boundary cases:
 - phase=0xFFF0, width=32, angle=0x0002 -> scheduled with diff=18.
 - angle=phase -> not scheduled.
 - diff=width+1 -> not scheduled.
REQ-034 Overrun: tooth at T and again at T+2 -> overrun=1 and the second tooth schedules nothing.
REQ-035 Simultaneous expiry: cyl0 and cyl1 with equal d, loaded one cycle apart -> sparks one cycle apart; with d differing by 1 (cyl1 smaller) -> spark=0011 in a single cycle.
REQ-036 Reset while both channels are pending -> no spark pulses ever; all outputs 0 from the cycle after reset.

Source files
------------

// File: rtl/ign_sched.sv
// Ignition scheduler: per-tooth cylinder scan feeding two spark timers.
// Each tooth latches a snapshot, scans four cylinders, arms free channels.
module ign_sched (
  input  logic        clk,
  input  logic        rst,
  input  logic        tooth,
  input  logic [15:0] eng_phase,
  input  logic [15:0] next_tooth_width,
  input  logic [31:0] tooth_period,
  input  logic [63:0] spark_angle,
  input  logic [3:0]  cyl_en,
  output logic [3:0]  spark,
  output logic [1:0]  chan_busy,
  output logic        sched_busy,
  output logic [7:0]  drop_cnt,
  output logic        overrun
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t state_q, state_d;
  logic [1:0] idx_q, idx_d;

  logic [15:0] phase_q;
  logic [15:0] width_q;
  logic [31:0] period_q;
  logic [63:0] angle_q;
  logic [3:0]  en_q;

  logic [1:0]       act_q;
  logic [1:0][31:0] cnt_q;
  logic [1:0][1:0]  own_q;

  logic [3:0] spark_q, spark_d;
  logic [1:0] busy_q, busy_d;
  logic       sbusy_q, sbusy_d;
  logic [7:0] drop_q, drop_d;
  logic       ovr_q, ovr_d;

  logic [15:0] ang_cur;
  logic [15:0] diff;
  logic [40:0] shv;
  logic [31:0] delay;
  logic        owned;
  logic        qual;
  logic [1:0]  ld;
  logic [1:0]  fire;
  logic        drop;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // FSM next state: a tooth in IDLE starts a fixed 4-cycle scan
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (tooth) begin
          state_d = SCAN;
          idx_d   = 2'd0;
        end
      end
      SCAN: begin
        idx_d = idx_q + 2'd1;
        if (idx_q == 2'd3) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Snapshot of engine inputs taken only when a scan is accepted
  always_ff @(posedge clk) begin
    if (state_q == IDLE && tooth) begin
      phase_q  <= eng_phase;
      width_q  <= next_tooth_width;
      period_q <= tooth_period;
      angle_q  <= spark_angle;
      en_q     <= cyl_en;
    end
  end

  // Window test and delay for the cylinder under scan
  always_comb begin
    ang_cur = angle_q[{idx_q, 4'b0000} +: 16];
    diff    = ang_cur - phase_q;
    shv     = 41'((48'(period_q) * 48'(diff)) >> 7);
    delay   = (|shv[40:32]) ? 32'hFFFF_FFFF : shv[31:0];
    owned   = (act_q[0] && own_q[0] == idx_q) ||
              (act_q[1] && own_q[1] == idx_q);
    qual    = (state_q == SCAN) && en_q[idx_q] &&
              (diff != 16'd0) && (diff <= width_q) && !owned;
  end

  // FSM outputs: channel allocation, expiry, flags
  always_comb begin
    ld      = 2'b00;
    drop    = 1'b0;
    fire    = 2'b00;
    spark_d = 4'b0000;
    if (qual) begin
      if (!act_q[0])      ld[0] = 1'b1;
      else if (!act_q[1]) ld[1] = 1'b1;
      else                drop  = 1'b1;
    end
    for (int j = 0; j < 2; j++) begin
      fire[j] = act_q[j] && (cnt_q[j] == 32'd0);
      if (fire[j]) spark_d = spark_d | (4'b0001 << own_q[j]);
    end
    busy_d  = ld | act_q;
    sbusy_d = (state_d == SCAN);
    ovr_d   = ovr_q | (tooth && state_q == SCAN);
    drop_d  = drop_q;
    if (drop && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
  end

  // Timer channels: load, count down, release on expiry
  always_ff @(posedge clk) begin
    if (rst) begin
      act_q <= 2'b00;
      cnt_q <= '0;
      own_q <= '0;
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (ld[j]) begin
          act_q[j] <= 1'b1;
          cnt_q[j] <= delay;
          own_q[j] <= idx_q;
        end else if (fire[j]) begin
          act_q[j] <= 1'b0;
        end else if (act_q[j]) begin
          cnt_q[j] <= cnt_q[j] - 32'd1;
        end
      end
    end
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      spark_q <= 4'b0000;
      busy_q  <= 2'b00;
      sbusy_q <= 1'b0;
      drop_q  <= 8'd0;
      ovr_q   <= 1'b0;
    end else begin
      spark_q <= spark_d;
      busy_q  <= busy_d;
      sbusy_q <= sbusy_d;
      drop_q  <= drop_d;
      ovr_q   <= ovr_d;
    end
  end

  assign spark      = spark_q;
  assign chan_busy  = busy_q;
  assign sched_busy = sbusy_q;
  assign drop_cnt   = drop_q;
  assign overrun    = ovr_q;

endmodule
